// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle CPU control core (fetch/decode, ALU handshake, regfile, PC, NZCV); define CPU_ILLEGAL_TRAP_EN to trap illegal opcodes
module cpu_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int IMM_W = 9,
  parameter int PC_W = 9,
  parameter int ALU_LAT = 1,
  localparam int INSTR_W = 5 + 2 * REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [IMM_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               alu_en,
  output logic [4:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [3:0]         alu_flags,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         flags,
  output logic               retire,
  output logic               halted,
  output logic               trap
);
  localparam int NREGS = 2 ** REG_AW;
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, ALU_WAIT, MEM, EXEC, HALT, TRAP} state_t;
  state_t state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, imm_pc, next_pc;
  logic [3:0] flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic alu_en_q, alu_en_d, retire_q, retire_d, wr_en, done;
  logic [IMM_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, wr_data;
  logic [4:0] alu_op_q, alu_op_d, op;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [REG_AW-1:0] rd, rs;
  logic [IMM_W-1:0] imm;
  assign op = instr_q[INSTR_W-1 -: 5];
  assign rd = instr_q[IMM_W+REG_AW +: REG_AW];
  assign rs = instr_q[IMM_W +: REG_AW];
  assign imm = instr_q[IMM_W-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign imm_pc = PC_W'(imm);
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d = pc_q;
    flags_d = flags_q;
    cnt_d = cnt_q;
    imem_req_d = imem_req_q;
    dmem_req_d = dmem_req_q;
    dmem_we_d = dmem_we_q;
    dmem_addr_d = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    alu_en_d = 1'b0;
    alu_op_d = alu_op_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    retire_d = 1'b0;
    wr_en = 1'b0;
    wr_data = alu_result;
    done = 1'b0;
    next_pc = pc_inc;
    case (state_q)
      FETCH: begin
        imem_req_d = !(imem_req_q && imem_ack);
        if (imem_req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op >= 5'd1 && op <= 5'd18) begin
          alu_en_d = 1'b1;
          alu_op_d = op;
          alu_a_d = rf_q[rs];
          alu_b_d = rf_q[imm[REG_AW-1:0]];
          cnt_d = '0;
          state_d = ALU_WAIT;
        end else if (op == 5'd20 || op == 5'd21) begin
          dmem_req_d = 1'b1;
          dmem_we_d = op == 5'd21;
          dmem_addr_d = imm;
          dmem_wdata_d = rf_q[rs];
          state_d = MEM;
        end else if (op == 5'd25)
          state_d = HALT;
`ifdef CPU_ILLEGAL_TRAP_EN
        else if (op == 5'd0 || op > 5'd25)
          state_d = TRAP;
`endif
        else
          state_d = EXEC;
      end
      ALU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ALU_LAT)) begin
          done = 1'b1;
          flags_d = alu_flags;
          wr_en = op != 5'd18;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          done = 1'b1;
          wr_en = !dmem_we_q;
          wr_data = dmem_rdata;
        end
      end
      EXEC: begin
        done = 1'b1;
        wr_en = op == 5'd22;
        wr_data = rf_q[rs];
        next_pc = (op == 5'd23 || (op == 5'd24 && rf_q[rd] == rf_q[rs])) ? imm_pc : pc_inc;
      end
      default: ;
    endcase
    if (done) begin
      state_d = FETCH;
      imem_req_d = 1'b1;
      retire_d = 1'b1;
      pc_d = next_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      instr_q <= '0;
      pc_q <= '0;
      flags_q <= '0;
      cnt_q <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q <= 1'b0;
      dmem_addr_q <= '0;
      dmem_wdata_q <= '0;
      alu_en_q <= 1'b0;
      alu_op_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      retire_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      flags_q <= flags_d;
      cnt_q <= cnt_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      alu_en_q <= alu_en_d;
      alu_op_q <= alu_op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      retire_q <= retire_d;
      if (wr_en) rf_q[rd] <= wr_data;
    end
  end
  assign imem_req = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign alu_en = alu_en_q;
  assign alu_op = alu_op_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign pc = pc_q;
  assign flags = flags_q;
  assign retire = retire_q;
  assign halted = state_q == HALT;
`ifdef CPU_ILLEGAL_TRAP_EN
  assign trap = state_q == TRAP;
`else
  assign trap = 1'b0;
`endif
endmodule
